pixel_fifo: RTL and testbench

Host-side pixel buffer that sits directly upstream of the parallel string wrapper. It accepts a byte stream from the host bus and packs byte pairs into 16-bit words. Words go into a simple-dual-port block-RAM FIFO. The FIFO exposes an occupancy count and a fixed two-cycle read pipeline, which is what the string wrapper uses to decide when a full frame is available and to pop colour data.

---
 rtl/pixel_fifo_pkg.sv | 24 ++
 rtl/pixel_fifo_if.sv | 50 +++++
 rtl/pixel_fifo_sdp_ram.sv | 37 +++
 rtl/pixel_fifo.sv | 194 +++++++++++++++++++
 tb/tb_pixel_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_fifo_pkg.sv
// pixel_fifo_pkg
// Shared constants and types for the host-side pixel FIFO.
//   PIXEL_FIFO_BYTES_PER_WORD : host bytes packed into one FIFO word
//   PIXEL_FIFO_READ_LATENCY   : cycles from an accepted rd_en to rd_data_valid;
//                               downstream consumers size their valid alignment
//                               delay from this value
//   pack_state_t              : byte packer state (waiting for low / high byte)
//   ptr_width()               : FIFO pointer width, one bit wider than the
//                               address so full and empty are distinguishable
package pixel_fifo_pkg;

  localparam int PIXEL_FIFO_BYTES_PER_WORD = 2;
  localparam int PIXEL_FIFO_READ_LATENCY   = 2;

  typedef enum logic {
    PACK_EMPTY = 1'b0,
    PACK_HALF  = 1'b1
  } pack_state_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pixel_fifo_if.sv
// pixel_fifo_if
// Host write / consumer read bundle of the pixel FIFO.
//   master modport : drives wr_byte, wr_byte_valid, wr_sof, rd_en, clear_flags
//   slave modport  : drives full_count, wr_full, rd_data, rd_data_valid,
//                    overflow, underflow
// With PIXEL_FIFO_STATS_EN defined the slave also drives frame_word_count and
// drop_count.
interface pixel_fifo_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) ();
  import pixel_fifo_pkg::*;

  logic [7:0]                         wr_byte;
  logic                               wr_byte_valid;
  logic                               wr_sof;
  logic [ptr_width(ADDR_WIDTH)-1:0]   full_count;
  logic                               wr_full;
  logic                               rd_en;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_data_valid;
  logic                               overflow;
  logic                               underflow;
  logic                               clear_flags;
`ifdef PIXEL_FIFO_STATS_EN
  logic [ptr_width(ADDR_WIDTH)-1:0]   frame_word_count;
  logic [15:0]                        drop_count;
`endif

  modport master (
    output wr_byte, output wr_byte_valid, output wr_sof,
    output rd_en, output clear_flags,
    input  full_count, input wr_full, input rd_data, input rd_data_valid,
    input  overflow, input underflow
`ifdef PIXEL_FIFO_STATS_EN
    , input frame_word_count, input drop_count
`endif
  );

  modport slave (
    input  wr_byte, input wr_byte_valid, input wr_sof,
    input  rd_en, input clear_flags,
    output full_count, output wr_full, output rd_data, output rd_data_valid,
    output overflow, output underflow
`ifdef PIXEL_FIFO_STATS_EN
    , output frame_word_count, output drop_count
`endif
  );

endinterface

// File: rtl/pixel_fifo_sdp_ram.sv
// sdp_ram
// Simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, for block-RAM inference.
//   clk   : clock
//   we    : write enable, waddr/wdata written at the clock edge
//   re    : read enable, rdata loads mem[raddr] at the clock edge
//   rdata : registered read data
// No reset: contents and rdata are undefined until written / read.
module sdp_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; the owner guarantees no same-address read/write.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Host-side pixel buffer: packs a host byte stream into 16-bit words (first
// byte in [7:0]) and stores them in a block-RAM FIFO with a registered
// occupancy count and a fixed two-cycle read pipeline.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pixel_fifo_if.slave (byte write side, word read side,
//                occupancy, sticky overflow/underflow with clear_flags)
// Optional: define PIXEL_FIFO_STATS_EN to add frame_word_count (words committed
// since the last wr_sof, saturating) and drop_count (dropped words, saturating,
// cleared by clear_flags).
// DATA_WIDTH must be 16: a word is exactly two host bytes.
module pixel_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  pixel_fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  pack_state_t           pack_state, pack_next;
  logic                  load_lo, commit_now;
  logic [7:0]            pack_lo;
  logic                  commit_valid;
  logic [DATA_WIDTH-1:0] commit_word;

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [PTR_W-1:0]      full_count_q;
  logic                  wr_full_q;
  logic                  do_write, do_read, drop_word, bad_pop;

  logic [PIXEL_FIFO_READ_LATENCY-1:0] rd_pipe;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q, underflow_q;

  // Packer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_state <= PACK_EMPTY;
    end else begin
      pack_state <= pack_next;
    end
  end

  // Packer decisions: a byte with wr_sof always restarts a word, dropping any
  // half-packed low byte; a lone wr_sof just discards the half word.
  always_comb begin
    pack_next  = pack_state;
    load_lo    = 1'b0;
    commit_now = 1'b0;
    if (bus.wr_byte_valid) begin
      if (bus.wr_sof || (pack_state == PACK_EMPTY)) begin
        load_lo   = 1'b1;
        pack_next = PACK_HALF;
      end else begin
        commit_now = 1'b1;
        pack_next  = PACK_EMPTY;
      end
    end else if (bus.wr_sof) begin
      pack_next = PACK_EMPTY;
    end
  end

  // Low-byte holding register and the one-cycle commit stage feeding the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_lo      <= '0;
      commit_valid <= 1'b0;
      commit_word  <= '0;
    end else begin
      if (load_lo) begin
        pack_lo <= bus.wr_byte;
      end
      commit_valid <= commit_now;
      if (commit_now) begin
        commit_word <= {bus.wr_byte, pack_lo};
      end
    end
  end

  // Full and empty decisions use only registered state, so a commit and a pop
  // in the same cycle both land except against an empty or full FIFO.
  assign do_write  = commit_valid && !wr_full_q;
  assign drop_word = commit_valid && wr_full_q;
  assign do_read   = bus.rd_en && (full_count_q != '0);
  assign bad_pop   = bus.rd_en && (full_count_q == '0);

  always_comb begin
    wr_ptr_next = do_write ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_next = do_read  ? rd_ptr + PTR_W'(1) : rd_ptr;
  end

  // Pointers, registered occupancy and registered full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      full_count_q <= '0;
      wr_full_q    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      full_count_q <= wr_ptr_next - rd_ptr_next;
      wr_full_q    <= ((wr_ptr_next - rd_ptr_next) == DEPTH);
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  && !bus.clear_flags) || drop_word;
      underflow_q <= (underflow_q && !bus.clear_flags) || bad_pop;
    end
  end

  // Read pipeline: stage 0 latches the address, the RAM reads on stage 0,
  // the output register loads on stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe    <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[PIXEL_FIFO_READ_LATENCY-2:0], do_read};
      if (do_read) begin
        rd_addr_q <= rd_ptr[ADDR_WIDTH-1:0];
      end
      rd_valid_q <= rd_pipe[PIXEL_FIFO_READ_LATENCY-1];
      if (rd_pipe[PIXEL_FIFO_READ_LATENCY-1]) begin
        rd_data_q <= ram_q;
      end
    end
  end

  sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (commit_word),
    .re    (rd_pipe[0]),
    .raddr (rd_addr_q),
    .rdata (ram_q)
  );

  assign bus.full_count    = full_count_q;
  assign bus.wr_full       = wr_full_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

`ifdef PIXEL_FIFO_STATS_EN
  logic [PTR_W-1:0] frame_words_q;
  logic [15:0]      drop_count_q;

  // Per-frame word counter and drop counter, both saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_words_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (bus.wr_sof) begin
        frame_words_q <= '0;
      end else if (do_write && (frame_words_q != '1)) begin
        frame_words_q <= frame_words_q + PTR_W'(1);
      end
      if (bus.clear_flags) begin
        drop_count_q <= drop_word ? 16'd1 : 16'd0;
      end else if (drop_word && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  assign bus.frame_word_count = frame_words_q;
  assign bus.drop_count       = drop_count_q;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo
// Self-checking bench for pixel_fifo: a queue-based reference model tracks the
// stored words, packer and sticky flags; a compare process checks every DUT
// output on each falling edge. Directed sequences add literal expectations.
module tb_pixel_fifo;
  import pixel_fifo_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;
  logic check_en;
  int   vectors;
  int   miscompares;

  pixel_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pixel_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [15:0] mq[$];
  logic        m_half, m_pend, m_valid, m_ovf, m_unf;
  logic [7:0]  m_lo;
  logic [15:0] m_pword, m_data;
  logic        s1v, s2v;
  logic [15:0] s1d, s2d;
  logic [15:0] fill_w;

  function automatic logic [15:0] fillWord(input int i);
    return 16'(i * 37 + 4096);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock edge of the model: pops leave in order with a fixed two-cycle
  // delay, commits arrive one cycle after the completing byte.
  task automatic modelStep();
    int   cnt;
    logic pop, wr;
    if (reset) begin
      mq.delete();
      m_half = 0; m_lo = 0; m_pend = 0; m_pword = 0;
      s1v = 0; s2v = 0; s1d = 0; s2d = 0;
      m_valid = 0; m_data = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    cnt = mq.size();
    pop = bus.rd_en && (cnt > 0);
    wr  = m_pend && (cnt < DEPTH);
    m_valid = s2v;
    if (s2v) m_data = s2d;
    s2v = s1v; s2d = s1d;
    s1v = pop;
    if (pop) s1d = mq[0];
    m_ovf = (m_ovf && !bus.clear_flags) || (m_pend && (cnt == DEPTH));
    m_unf = (m_unf && !bus.clear_flags) || (bus.rd_en && (cnt == 0));
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back(m_pword);
    m_pend = 0;
    if (bus.wr_byte_valid) begin
      if (bus.wr_sof || !m_half) begin
        m_lo = bus.wr_byte; m_half = 1;
      end else begin
        m_pword = {bus.wr_byte, m_lo}; m_pend = 1; m_half = 0;
      end
    end else if (bus.wr_sof) begin
      m_half = 0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic v, input logic sof,
                               input logic rd, input logic clr, input logic rst);
    bus.wr_byte       = b;
    bus.wr_byte_valid = v;
    bus.wr_sof        = sof;
    bus.rd_en         = rd;
    bus.clear_flags   = clr;
    reset             = rst;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic writeByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("full_count", 32'(bus.full_count), 32'(mq.size()));
      checkOutput("wr_full", 32'(bus.wr_full), 32'(mq.size() == DEPTH));
      checkOutput("rd_data_valid", 32'(bus.rd_data_valid), 32'(m_valid));
      checkOutput("rd_data", 32'(bus.rd_data), 32'(m_data));
      checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
      checkOutput("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  initial begin
    vectors = 0; miscompares = 0; check_en = 1'b0;
    bus.wr_byte = 8'h00; bus.wr_byte_valid = 1'b0; bus.wr_sof = 1'b0;
    bus.rd_en = 1'b0; bus.clear_flags = 1'b0; reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    idle(1);
    checkOutput("reset_count", 32'(bus.full_count), 32'd0);
    checkOutput("reset_valid", 32'(bus.rd_data_valid), 32'd0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);

    // Two words, read back in order.
    writeByte(8'h34); writeByte(8'h12); writeByte(8'h78); writeByte(8'h56);
    idle(1);
    checkOutput("pair_count", 32'(bus.full_count), 32'd2);
    popWord(); popWord(); idle(1);
    checkOutput("first_valid", 32'(bus.rd_data_valid), 32'd1);
    checkOutput("first_word", 32'(bus.rd_data), 32'h1234);
    idle(1);
    checkOutput("second_word", 32'(bus.rd_data), 32'h5678);

    // wr_sof discards the half word, alone and together with a byte.
    doReset();
    writeByte(8'hAA);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    writeByte(8'h01); writeByte(8'h02); idle(1);
    checkOutput("sof_count", 32'(bus.full_count), 32'd1);
    popWord(); idle(2);
    checkOutput("sof_word", 32'(bus.rd_data), 32'h0201);
    writeByte(8'h55);
    applyStimulus(8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    writeByte(8'h77); idle(1);
    popWord(); idle(2);
    checkOutput("sof_byte_word", 32'(bus.rd_data), 32'h7766);

    // Reset with a half-packed word pending.
    writeByte(8'h99);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("midreset_count", 32'(bus.full_count), 32'd0);
    writeByte(8'h11); writeByte(8'h22); idle(1);
    popWord(); idle(2);
    checkOutput("midreset_word", 32'(bus.rd_data), 32'h2211);

    // Fill to full, then overflow with one extra word.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      fill_w = fillWord(i);
      writeByte(fill_w[7:0]);
      writeByte(fill_w[15:8]);
    end
    writeByte(8'hEE); writeByte(8'hFF); idle(2);
    checkOutput("full_flag", 32'(bus.wr_full), 32'd1);
    checkOutput("full_count_max", 32'(bus.full_count), 32'd4096);
    checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
    popWord(); idle(2);
    checkOutput("first_fill_word", 32'(bus.rd_data), 32'h1000);

    // Drain to 5 words, commit and pop on one edge, then read across the wrap.
    for (int i = 0; i < DEPTH - 6; i++) popWord();
    writeByte(8'hEF); writeByte(8'hBE);
    checkOutput("count_before_mix", 32'(bus.full_count), 32'd5);
    popWord();
    checkOutput("count_after_mix", 32'(bus.full_count), 32'd5);
    for (int i = 0; i < 5; i++) popWord();
    idle(3);
    checkOutput("last_wrapped_word", 32'(bus.rd_data), 32'hBEEF);
    checkOutput("drained_count", 32'(bus.full_count), 32'd0);

    // Underflow and flag clearing.
    popWord();
    checkOutput("underflow_set", 32'(bus.underflow), 32'd1);
    idle(2);
    checkOutput("underflow_no_valid", 32'(bus.rd_data_valid), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("underflow_cleared", 32'(bus.underflow), 32'd0);
    checkOutput("overflow_cleared", 32'(bus.overflow), 32'd0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 299) == 0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
